// File: rtl/collision_pkg.sv
// Shared constants and types for the collision scheduler: the box word layout
// and the scan state encoding.
package collision_pkg;

  localparam int COORD_W = 11;
  localparam int BOX_W   = 4 * COORD_W;

  // Field offsets inside one box word: {bottomy, topy, rightx, leftx}
  localparam int BOT_Y   = 3 * COORD_W;
  localparam int TOP_Y   = 2 * COORD_W;
  localparam int RIGHT_X = 1 * COORD_W;
  localparam int LEFT_X  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

endpackage

// File: rtl/collision_scheduler_if.sv
// Bus between the position registers / game-state logic (master) and the
// collision scheduler (slave).
interface collision_scheduler_if #(
  parameter int NUM_BULLETS = 4,
  parameter int NUM_TARGETS = 8,
  parameter int COORD_W     = collision_pkg::COORD_W
);
  localparam int BOX_W = 4 * COORD_W;
  localparam int CNT_W = $clog2(NUM_BULLETS + 1);

  logic                           start;
  logic [NUM_BULLETS-1:0]         bullet_valid;
  logic [NUM_BULLETS*BOX_W-1:0]   bullet_boxes;
  logic [NUM_TARGETS-1:0]         target_alive;
  logic [NUM_TARGETS*BOX_W-1:0]   target_boxes;
  logic                           busy;
  logic                           done;
  logic [NUM_BULLETS-1:0]         bullet_hit;
  logic [NUM_TARGETS-1:0]         target_hit;
  logic [CNT_W-1:0]               hit_count;

  modport master (
    output start, bullet_valid, bullet_boxes, target_alive, target_boxes,
    input  busy, done, bullet_hit, target_hit, hit_count
  );

  modport slave (
    input  start, bullet_valid, bullet_boxes, target_alive, target_boxes,
    output busy, done, bullet_hit, target_hit, hit_count
  );

endinterface

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test, inclusive on every edge.
module box_overlap
  import collision_pkg::*;
(
  input  logic [BOX_W-1:0] bullet_box,
  input  logic [BOX_W-1:0] target_box,
  output logic             overlap
);

  logic [COORD_W-1:0] b_left, b_right, b_top, b_bot;
  logic [COORD_W-1:0] t_left, t_right, t_top, t_bot;

  assign b_left  = bullet_box[LEFT_X  +: COORD_W];
  assign b_right = bullet_box[RIGHT_X +: COORD_W];
  assign b_top   = bullet_box[TOP_Y   +: COORD_W];
  assign b_bot   = bullet_box[BOT_Y   +: COORD_W];
  assign t_left  = target_box[LEFT_X  +: COORD_W];
  assign t_right = target_box[RIGHT_X +: COORD_W];
  assign t_top   = target_box[TOP_Y   +: COORD_W];
  assign t_bot   = target_box[BOT_Y   +: COORD_W];

  // y grows downward, so "top" is the smaller y value
  assign overlap = (b_left <= t_right) && (b_right >= t_left) &&
                   (b_top  <= t_bot)   && (b_bot   >= t_top);

endmodule

// File: rtl/collision_scheduler.sv
// Scans every (bullet, alien) pair once per frame tick through a single
// shared overlap checker; each bullet and each alien is consumed at most once,
// with the lowest index winning through scan order.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int NUM_TARGETS = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  collision_scheduler_if.slave  bus
);

  localparam int BW    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int TW    = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CNT_W = $clog2(NUM_BULLETS + 1);

  localparam logic [BW-1:0] B_LAST = BW'(NUM_BULLETS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_TARGETS - 1);

  state_e                 state_q, state_d;
  logic [BW-1:0]          b_q, b_d;
  logic [TW-1:0]          t_q, t_d;
  logic [NUM_BULLETS-1:0] valid_q, valid_d;
  logic [NUM_TARGETS-1:0] alive_q, alive_d;
  logic [NUM_BULLETS-1:0] bullet_hit_q, bullet_hit_d;
  logic [NUM_TARGETS-1:0] target_hit_q, target_hit_d;
  logic [CNT_W-1:0]       hit_count_q, hit_count_d;

  logic [BOX_W-1:0] cur_bullet_box;
  logic [BOX_W-1:0] cur_target_box;
  logic             pair_overlap;
  logic             pair_hit;

  // The single checker sees whichever pair the counters currently select
  assign cur_bullet_box = bus.bullet_boxes[int'(b_q) * BOX_W +: BOX_W];
  assign cur_target_box = bus.target_boxes[int'(t_q) * BOX_W +: BOX_W];

  box_overlap u_overlap (
    .bullet_box (cur_bullet_box),
    .target_box (cur_target_box),
    .overlap    (pair_overlap)
  );

  // Both sides must still be free; the hit masks double as "already consumed"
  assign pair_hit = valid_q[b_q] && !bullet_hit_q[b_q] &&
                    alive_q[t_q] && !target_hit_q[t_q] && pair_overlap;

  // Next-state, counter and hit-mask update
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d      = state_q;
    b_d          = b_q;
    t_d          = t_q;
    valid_d      = valid_q;
    alive_d      = alive_q;
    bullet_hit_d = bullet_hit_q;
    target_hit_d = target_hit_q;
    hit_count_d  = hit_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          valid_d      = bus.bullet_valid;
          alive_d      = bus.target_alive;
          bullet_hit_d = '0;
          target_hit_d = '0;
          hit_count_d  = '0;
          b_d          = '0;
          t_d          = '0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pair_hit) begin
          bullet_hit_d[b_q] = 1'b1;
          target_hit_d[t_q] = 1'b1;
          hit_count_d       = hit_count_q + 1'b1;
        end
        // Terminal compares end the pass; the counters never wrap into a second one
        if (t_q == T_LAST) begin
          t_d = '0;
          if (b_q == B_LAST) state_d = S_DONE;
          else               b_d     = b_q + 1'b1;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset drops any scan in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      b_q          <= '0;
      t_q          <= '0;
      valid_q      <= '0;
      alive_q      <= '0;
      bullet_hit_q <= '0;
      target_hit_q <= '0;
      hit_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      b_q          <= b_d;
      t_q          <= t_d;
      valid_q      <= valid_d;
      alive_q      <= alive_d;
      bullet_hit_q <= bullet_hit_d;
      target_hit_q <= target_hit_d;
      hit_count_q  <= hit_count_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.bullet_hit = bullet_hit_q;
  assign bus.target_hit = target_hit_q;
  assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: directed vector table, reset and
// start-ignore sequences, then random frames against a greedy matching model.
module tb_collision_scheduler;

  localparam int NB    = 4;
  localparam int NT    = 8;
  localparam int BOXW  = 44;
  localparam int LAT   = NB * NT + 1;

  typedef struct {
    string            name;
    logic [NB-1:0]    bv;
    logic [NT-1:0]    ta;
    logic [NB*BOXW-1:0] bb;
    logic [NT*BOXW-1:0] tbx;
    logic [NB-1:0]    eb;
    logic [NT-1:0]    et;
    logic [2:0]       ec;
    int               restart_at;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  collision_scheduler_if #(.NUM_BULLETS(NB), .NUM_TARGETS(NT)) bus ();

  collision_scheduler #(.NUM_BULLETS(NB), .NUM_TARGETS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BOXW-1:0] mk(input int bot, input int top, input int right, input int left);
    return {11'(bot), 11'(top), 11'(right), 11'(left)};
  endfunction

  // Inclusive overlap on plain integers
  function automatic bit ovl(input logic [BOXW-1:0] a, input logic [BOXW-1:0] b);
    int al, ar, at, ab, bl, br, bt, bbt;
    al = int'(a[10:0]);  ar = int'(a[21:11]); at = int'(a[32:22]); ab  = int'(a[43:33]);
    bl = int'(b[10:0]);  br = int'(b[21:11]); bt = int'(b[32:22]); bbt = int'(b[43:33]);
    return (al <= br) && (ar >= bl) && (at <= bbt) && (ab >= bt);
  endfunction

  // Greedy matching: each valid bullet, in index order, takes the lowest-index
  // alive alien it overlaps that no earlier bullet has already claimed
  function automatic void ref_model(input logic [NB-1:0] bv, input logic [NT-1:0] ta,
                                    input logic [NB*BOXW-1:0] bb, input logic [NT*BOXW-1:0] tbx,
                                    output logic [NB-1:0] eb, output logic [NT-1:0] et,
                                    output logic [2:0] ec);
    eb = '0; et = '0; ec = '0;
    for (int i = 0; i < NB; i++) begin
      if (bv[i]) begin
        for (int j = 0; j < NT; j++) begin
          if (ta[j] && !et[j] && ovl(bb[i*BOXW +: BOXW], tbx[j*BOXW +: BOXW])) begin
            eb[i] = 1'b1;
            et[j] = 1'b1;
            ec    = ec + 3'd1;
            break;
          end
        end
      end
    end
  endfunction

  // Bullets parked near the bottom, aliens near the top: nothing overlaps
  function automatic vec_t blank(input string name);
    vec_t v;
    v.name = name; v.bv = '0; v.ta = '0; v.eb = '0; v.et = '0; v.ec = '0; v.restart_at = 0;
    v.bb = '0; v.tbx = '0;
    for (int i = 0; i < NB; i++) v.bb[i*BOXW +: BOXW]  = mk(1910, 1900, 20*i + 10, 20*i);
    for (int j = 0; j < NT; j++) v.tbx[j*BOXW +: BOXW] = mk(20, 10, 20*j + 10, 20*j);
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    int  cyc;
    bit  busy_dropped;
    @(negedge clk);
    bus.bullet_valid = v.bv;
    bus.target_alive = v.ta;
    bus.bullet_boxes = v.bb;
    bus.target_boxes = v.tbx;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    cyc          = 1;
    busy_dropped = 0;
    check({v.name, " busy_after_start"}, 64'(bus.busy), 64'd1);
    while (!bus.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!bus.busy) busy_dropped = 1;
      if (v.restart_at > 0 && cyc == v.restart_at) begin
        // Masks change and start re-pulses mid-scan; neither may affect the frame
        bus.start        = 1'b1;
        bus.bullet_valid = ~v.bv;
        bus.target_alive = '1;
      end else if (v.restart_at > 0 && cyc == v.restart_at + 1) begin
        bus.start        = 1'b0;
        bus.bullet_valid = v.bv;
        bus.target_alive = v.ta;
      end
    end
    check({v.name, " done_cycle"}, 64'(cyc), 64'(LAT));
    check({v.name, " busy_held"}, 64'(busy_dropped), 64'd0);
    check({v.name, " bullet_hit"}, 64'(bus.bullet_hit), 64'(v.eb));
    check({v.name, " target_hit"}, 64'(bus.target_hit), 64'(v.et));
    check({v.name, " hit_count"}, 64'(bus.hit_count), 64'(v.ec));
    @(negedge clk);
    check({v.name, " done_one_cycle"}, 64'({bus.done, bus.busy}), 64'd0);
    check({v.name, " masks_hold"}, {bus.bullet_hit, bus.target_hit, bus.hit_count}, {v.eb, v.et, v.ec});
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int   saw_done;

    // Single hit: bullet0 vs alien3
    v = blank("single_hit");
    v.bb[0*BOXW +: BOXW]  = mk(110, 100, 52, 50);
    v.tbx[3*BOXW +: BOXW] = mk(115, 105, 60, 40);
    v.bv = 4'b0001; v.ta = 8'b0000_1000; v.eb = 4'b0001; v.et = 8'b0000_1000; v.ec = 3'd1;
    vecs[0] = v;
    // Edge touch: bullet left == alien right
    v = blank("edge_touch");
    v.bb[0*BOXW +: BOXW]  = mk(110, 100, 70, 60);
    v.tbx[0*BOXW +: BOXW] = mk(110, 100, 60, 50);
    v.bv = 4'b0001; v.ta = 8'b0000_0001; v.eb = 4'b0001; v.et = 8'b0000_0001; v.ec = 3'd1;
    vecs[1] = v;
    // One bullet overlapping aliens 2 and 5: lowest alien wins
    v = blank("one_bullet_two_aliens");
    v.bb[1*BOXW +: BOXW]  = mk(210, 200, 310, 300);
    v.tbx[2*BOXW +: BOXW] = mk(215, 205, 305, 295);
    v.tbx[5*BOXW +: BOXW] = mk(212, 202, 320, 308);
    v.bv = 4'b0010; v.ta = 8'b0010_0100; v.eb = 4'b0010; v.et = 8'b0000_0100; v.ec = 3'd1;
    vecs[2] = v;
    // Bullets 0 and 2 both overlap alien4: lowest bullet wins
    v = blank("two_bullets_one_alien");
    v.bb[0*BOXW +: BOXW]  = mk(60, 50, 60, 50);
    v.bb[2*BOXW +: BOXW]  = mk(62, 52, 62, 52);
    v.tbx[4*BOXW +: BOXW] = mk(70, 40, 70, 40);
    v.bv = 4'b0101; v.ta = 8'b0001_0000; v.eb = 4'b0001; v.et = 8'b0001_0000; v.ec = 3'd1;
    vecs[3] = v;
    // Overlap with an invalid bullet, plus mid-scan start and mask change
    v = blank("masked_restart");
    v.bb[3*BOXW +: BOXW]  = mk(110, 100, 52, 50);
    v.tbx[3*BOXW +: BOXW] = mk(115, 105, 60, 40);
    v.bv = 4'b0111; v.ta = 8'b0000_1000; v.restart_at = 5;
    vecs[4] = v;
    // Overlap present but no alien alive
    v = vecs[0]; v.name = "no_alive"; v.ta = '0; v.eb = '0; v.et = '0; v.ec = '0;
    vecs[5] = v;
    // Four independent hits: bullet i on alien 2i
    v = blank("four_hits");
    for (int i = 0; i < NB; i++) begin
      v.bb[i*BOXW +: BOXW]      = mk(310, 300, 100*i + 10, 100*i);
      v.tbx[2*i*BOXW +: BOXW]   = mk(310, 300, 100*i + 10, 100*i);
    end
    v.bv = 4'hF; v.ta = 8'hFF; v.eb = 4'hF; v.et = 8'h55; v.ec = 3'd4;
    vecs[6] = v;

    // Reset state
    rst = 1'b1;
    bus.start = 1'b0; bus.bullet_valid = '0; bus.target_alive = '0;
    bus.bullet_boxes = '0; bus.target_boxes = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.busy, bus.done, bus.bullet_hit, bus.target_hit, bus.hit_count}, '0);
    rst = 1'b0;

    foreach (vecs[k]) run_frame(vecs[k]);

    // Reset in the middle of a scan that has already registered a hit
    @(negedge clk);
    bus.bullet_valid = vecs[0].bv; bus.target_alive = vecs[0].ta;
    bus.bullet_boxes = vecs[0].bb; bus.target_boxes = vecs[0].tbx;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_hit", 64'(bus.bullet_hit), 64'd1);
    rst = 1'b1;
    #1;
    check("midscan_reset_busy", 64'({bus.busy, bus.done}), 64'd0);
    check("midscan_reset_masks", {bus.bullet_hit, bus.target_hit, bus.hit_count}, '0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1;
    end
    check("no_done_after_reset", 64'(saw_done), 64'd0);
    run_frame(vecs[0]);

    // start asserted together with rst is ignored
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("start_during_rst_ignored", 64'(bus.busy), 64'd0);

    // Random frames against the reference model
    for (int r = 0; r < 40; r++) begin
      v = blank($sformatf("rand%0d", r));
      for (int i = 0; i < NB; i++) begin
        int l, t;
        l = $urandom_range(0, 100); t = $urandom_range(0, 100);
        v.bb[i*BOXW +: BOXW] = mk(t + $urandom_range(0, 20), t, l + $urandom_range(0, 20), l);
      end
      for (int j = 0; j < NT; j++) begin
        int l, t;
        l = $urandom_range(0, 100); t = $urandom_range(0, 100);
        v.tbx[j*BOXW +: BOXW] = mk(t + $urandom_range(0, 20), t, l + $urandom_range(0, 20), l);
      end
      v.bv = NB'($urandom);
      v.ta = NT'($urandom);
      ref_model(v.bv, v.ta, v.bb, v.tbx, v.eb, v.et, v.ec);
      run_frame(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
